// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared width encodings, FSM states and requester ids for the memory arbiter
package mem_arbiter_pkg;
   localparam logic [1:0] WDT8  = 2'd0;
   localparam logic [1:0] WDT16 = 2'd1;
   localparam logic [1:0] WDT32 = 2'd2;
   localparam logic [1:0] WDT64 = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
   typedef enum logic {REQ_IF, REQ_LS} req_id_e;

   function automatic logic [7:0] wdt_base(input logic [1:0] wdt);
      return wdt == WDT8 ? 8'h01 : wdt == WDT16 ? 8'h03 : wdt == WDT32 ? 8'h0F : 8'hFF;
   endfunction

   function automatic logic [63:0] wdt_mask(input logic [1:0] wdt);
      return wdt == WDT8 ? 64'hFF : wdt == WDT16 ? 64'hFFFF : wdt == WDT32 ? 64'hFFFF_FFFF : '1;
   endfunction
endpackage

// File: rtl/mem_arbiter_lane_align.sv
// mem_arbiter_lane_align: byte-lane mask, store shift, load extraction and alignment check
module mem_arbiter_lane_align
   import mem_arbiter_pkg::*;
(
   input  logic [1:0]  wdt,
   input  logic [2:0]  off,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [7:0]  wmask,
   output logic [63:0] wdata_sh,
   output logic [63:0] rdata_ex,
   output logic        misalign
);
   // lanes are selected purely by the low address bits of the 8-byte word
   always_comb begin
      wmask    = wdt_base(wdt) << off;
      wdata_sh = wdata << {off, 3'b000};
      rdata_ex = (rdata >> {off, 3'b000}) & wdt_mask(wdt);
      misalign = (wdt == WDT16 && off[0]) || (wdt == WDT32 && off[1:0] != 2'b00) || (wdt == WDT64 && off != 3'b000);
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the 64-bit memory port between fetch and load/store
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int WDT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_resp_valid,
   output logic [31:0]       if_resp_inst,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic [ADDR_W-1:0] ls_req_addr,
   input  logic              ls_req_wen,
   input  logic [WDT_W-1:0]  ls_req_wdt,
   input  logic [DATA_W-1:0] ls_req_wdata,
   output logic              ls_resp_valid,
   output logic [DATA_W-1:0] ls_resp_rdata,
   output logic              ls_resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_wen,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [7:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_rdata
);
   state_e            state, state_n;
   req_id_e           last_grant, cur_id;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [1:0]        wdt_q;
   logic [DATA_W-1:0] wdata_q;
   logic              grant_if, grant_ls, accept, misalign;
   logic [1:0]        la_wdt;
   logic [2:0]        la_off;
   logic [7:0]        la_wmask;
   logic [63:0]       la_wdata, la_rdata;

   // in IDLE the aligner looks at the live LS request so misalignment is known at accept time
   always_comb begin
      grant_ls     = ls_req_valid && (!if_req_valid || last_grant == REQ_IF);
      grant_if     = if_req_valid && !grant_ls;
      accept       = state == S_IDLE && (grant_if || grant_ls);
      if_req_ready = !rst && state == S_IDLE && grant_if;
      ls_req_ready = !rst && state == S_IDLE && grant_ls;
      la_wdt       = state == S_IDLE ? ls_req_wdt[1:0] : wdt_q;
      la_off       = state == S_IDLE ? ls_req_addr[2:0] : addr_q[2:0];
      mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
      mem_req_wen   = wen_q;
      mem_req_wdata = wen_q ? la_wdata : '0;
      mem_req_wmask = wen_q ? la_wmask : 8'h00;
   end

   mem_arbiter_lane_align u_lane (
      .wdt      (la_wdt),
      .off      (la_off),
      .wdata    (wdata_q),
      .rdata    (mem_resp_rdata),
      .wmask    (la_wmask),
      .wdata_sh (la_wdata),
      .rdata_ex (la_rdata),
      .misalign (misalign)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // next state and per-state strobes
   always_comb begin
      state_n       = state;
      mem_req_valid = 1'b0;
      if_resp_valid = 1'b0;
      ls_resp_valid = 1'b0;
      case (state)
         S_IDLE: if (accept) state_n = (grant_ls && misalign) ? S_RESP : S_REQ;
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_n = S_WAIT;
         end
         S_WAIT: if (mem_resp_valid) state_n = S_RESP;
         S_RESP: begin
            if_resp_valid = cur_id == REQ_IF;
            ls_resp_valid = cur_id == REQ_LS;
            state_n       = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // request capture on accept and response capture on memory data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant    <= REQ_LS;
         cur_id        <= REQ_IF;
         addr_q        <= '0;
         wen_q         <= 1'b0;
         wdt_q         <= WDT8;
         wdata_q       <= '0;
         if_resp_inst  <= '0;
         ls_resp_rdata <= '0;
         ls_resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cur_id      <= grant_ls ? REQ_LS : REQ_IF;
            last_grant  <= grant_ls ? REQ_LS : REQ_IF;
            addr_q      <= grant_ls ? ls_req_addr : if_req_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
            wen_q       <= grant_ls && ls_req_wen;
            wdt_q       <= grant_ls ? ls_req_wdt[1:0] : WDT32;
            wdata_q     <= grant_ls ? ls_req_wdata : '0;
            ls_resp_err <= grant_ls && misalign;
            if (grant_ls && misalign) ls_resp_rdata <= '0;
         end
         if (state == S_WAIT && mem_resp_valid) begin
            if (cur_id == REQ_IF) if_resp_inst <= addr_q[2] ? mem_resp_rdata[63:32] : mem_resp_rdata[31:0];
            else                  ls_resp_rdata <= wen_q ? '0 : la_rdata;
         end
      end
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 64-bit data-memory port between instruction fetch (IF, read-only, 32-bit) and load/store (LS, 8/16/32/64-bit read or write).
- Arbitrates round-robin and allows one outstanding transaction.
- Builds the byte write mask and lane-shifted write data, and extracts the read lane.
- Rejects misaligned LS accesses without touching memory; sits between the IFU/LSU and the memory model.

Parameters:
- ADDR_W, 64: address width.
- DATA_W, 64: memory data width (fixed 64; 8 byte lanes).
- WDT_W, 2: width-op encoding width.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  one-cycle fetch response strobe
- if_resp_inst  out  32  instruction word selected by addr[2]
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_req_addr  in  ADDR_W  LS address
- ls_req_wen  in  1  1=store, 0=load
- ls_req_wdt  in  WDT_W  access width (Wdt8/16/32/64)
- ls_req_wdata  in  DATA_W  store data, right-aligned
- ls_resp_valid  out  1  one-cycle LS response strobe
- ls_resp_rdata  out  DATA_W  load data, lane-extracted, zero-extended
- ls_resp_err  out  1  misaligned, no access performed
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  address forced 8-byte aligned (addr & ~7)
- mem_req_wen  out  1  write
- mem_req_wdata  out  DATA_W  lane-shifted store data
- mem_req_wmask  out  8  byte enables
- mem_resp_valid  in  1  read data / write ack
- mem_resp_rdata  in  DATA_W  raw 64-bit word

Behaviour:
- Clock clk; reset rst is asynchronous, active-high.
- Reset: state=IDLE, last_grant=LS, all out valids/readies/err=0, captured regs=0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, arbitration:
  - Grant goes to the single requester.
  - If both request, grant goes to the requester not equal to last_grant.
  - Matching *_req_ready is combinational: (state==IDLE) & grant.
  - On accept: latch requester id, addr, wen, wdt, wdata; update last_grant.
- IDLE misalign check (LS only): Wdt16 with addr[0]!=0; Wdt32 with addr[1:0]!=0; Wdt64 with addr[2:0]!=0.
  - Misaligned accept goes IDLE->RESP with err=1; mem_req_valid is never raised.
- IF is always treated as Wdt32. A misaligned IF address is truncated to a 4-byte boundary (no error).
- REQ: mem_req_valid=1, fields stable until mem_req_ready. On ready -> WAIT.
- WAIT: on mem_resp_valid, capture mem_resp_rdata -> RESP.
  - mem_resp_valid is ignored in IDLE and REQ.
- RESP: drives exactly one cycle of *_resp_valid for the latched requester -> IDLE.
  - Other requester's resp_valid=0. ls_resp_err=0 except on the misaligned path.
- Latency: accept at cycle N; mem_req_valid at N+1; with ready=1 and resp one cycle later, resp_valid at N+3.
  - Earliest next accept: N+4. Misaligned path: resp_valid at N+1.
- wmask = base << addr[2:0]; base is 01/03/0F/FF for Wdt8/16/32/64. Reads drive wmask=0.
- mem_req_wdata = ls_wdata << (8*addr[2:0]); bits shifted out are discarded.
- Load data = rdata >> (8*addr[2:0]), masked to width, zero-extended. Sign extension is the LSU's job.
- if_resp_inst = addr[2] ? rdata[63:32] : rdata[31:0].
- Stores still wait for mem_resp_valid (ack); ls_resp_rdata=0 for stores.
- Response outputs hold their last value when not valid; consumers must qualify with valid.
- Requests that drop valid before acceptance are not remembered.
- Reset mid-transaction: immediate return to IDLE, transaction abandoned, no response emitted.

Decomposition:
- Shared package: Wdt8/16/32/64 encodings, state enum, requester-id enum (REQ_IF, REQ_LS).
- Sub-module lane_align: combinational; takes wdt and addr[2:0]; produces wmask, shifted wdata, extracted rdata and misalign flag.

Test Plan:
- Both request at reset with IF addr 0x80000004 and LS load Wdt32 at 0x80000010 -> IF granted first.
  - mem_req_addr 0x80000000; if_resp_inst = rdata[63:32]; LS served next; last_grant alternates.
- LS store Wdt8 at 0x80000003 with wdata 0xAB -> wmask 0x08, mem_req_wdata 0x00000000AB000000, mem_req_wen=1.
  - ls_resp_valid only after the memory ack.
- LS load Wdt16 at 0x80000006 with rdata 0x1122334455667788 -> ls_resp_rdata 0x1122.
- LS load Wdt32 at 0x80000002 -> ls_resp_err=1 at N+1; mem_req_valid stays 0 throughout.
- mem_req_ready held 0 for 5 cycles -> mem_req_* stable; no second accept; if_req_ready=0 during the stall.
- rst asserted in WAIT, then a stray mem_resp_valid -> all outputs 0 immediately; no resp_valid afterwards; next request is granted normally.
